// File: rtl/i2s_stereo_core_if.sv
// ============================================================================
//  Module   : i2s_stereo_core_if
//  Brief    : Parallel word-pair bus between the I2S stereo core and the DSP.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface i2s_stereo_core_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] txLeft_i;
    logic [WIDTH-1:0] txRight_i;
    logic             txValid_i;
    logic [WIDTH-1:0] rxLeft_o;
    logic [WIDTH-1:0] rxRight_o;
    logic             rxValid_o;

    // Core side of the bus
    modport slave (
        input  mode_i, txLeft_i, txRight_i, txValid_i,
        output rxLeft_o, rxRight_o, rxValid_o
    );

    // DSP side of the bus
    modport master (
        output mode_i, txLeft_i, txRight_i, txValid_i,
        input  rxLeft_o, rxRight_o, rxValid_o
    );
endinterface

`default_nettype wire

// File: rtl/i2s_stereo_core.sv
// ============================================================================
//  Module   : i2s_stereo_core
//  Brief    : Full-duplex I2S slave with stereo capture, frame-coherent
//             transmit (normal / loopback / swap / mute) and sticky underrun.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_stereo_core #(
    parameter int WIDTH = 16
) (
    input  wire logic         sclk_i,
    input  wire logic         rst_n_i,
    input  wire logic         ws_i,
    input  wire logic         sdata_i,
    output logic              sclk_o,
    output logic              ws_o,
    output logic              sdata_o,
    output logic              underrun_o,
    i2s_stereo_core_if.slave  dsp
);

    localparam int               c_CW          = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_CNT_MAX     = c_CW'(WIDTH);
    localparam logic [WIDTH-1:0] c_MSB         = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0]       c_MODE_NORMAL = 2'b00;
    localparam logic [1:0]       c_MODE_LOOP   = 2'b01;
    localparam logic [1:0]       c_MODE_SWAP   = 2'b11;

    logic              r_wsQ;
    logic              r_wsSeen;
    logic [c_CW-1:0]   r_bitCnt;
    logic [WIDTH-1:0]  r_rxSh;
    logic [WIDTH-1:0]  r_rxLHold;
    logic              r_slotOk;
    logic              r_leftOk;
    logic [WIDTH-1:0]  r_rxLeft;
    logic [WIDTH-1:0]  r_rxRight;
    logic              r_rxValid;
    logic [WIDTH-1:0]  r_holdL;
    logic [WIDTH-1:0]  r_holdR;
    logic              r_fresh;
    logic              r_txArmed;
    logic [WIDTH-1:0]  r_actL;
    logic [WIDTH-1:0]  r_actR;
    logic              r_underrun;
    logic [WIDTH-1:0]  r_txSh;
    logic              r_sdata;

    logic              w_boundary;
    logic              w_fall;
    logic              w_rise;
    logic [WIDTH-1:0]  w_sampleMask;
    logic [WIDTH-1:0]  w_rxWord;
    logic [WIDTH-1:0]  w_nextL;
    logic [WIDTH-1:0]  w_nextR;
    logic              w_underrunHit;

    // The first edge after reset only primes r_wsQ, so a stale reset value
    // can never fake a slot boundary.
    assign w_boundary   = r_wsSeen & (ws_i ^ r_wsQ);
    assign w_fall       = w_boundary & ~ws_i;
    assign w_rise       = w_boundary &  ws_i;

    // Bit position for the current sample; zero once the word is full, which
    // drops overlong slot bits and leaves short-slot LSBs at zero.
    assign w_sampleMask = c_MSB >> r_bitCnt;
    assign w_rxWord     = r_rxSh | (sdata_i ? w_sampleMask : '0);

    always_comb begin
        w_nextL       = r_actL;
        w_nextR       = r_actR;
        w_underrunHit = 1'b0;
        case (dsp.mode_i)
            c_MODE_NORMAL: begin
                if (dsp.txValid_i) begin
                    w_nextL = dsp.txLeft_i;
                    w_nextR = dsp.txRight_i;
                end else if (r_txArmed && !r_fresh) begin
                    w_underrunHit = 1'b1;
                end else begin
                    w_nextL = r_holdL;
                    w_nextR = r_holdR;
                end
            end
            c_MODE_LOOP: begin
                w_nextL = r_rxLHold;
                w_nextR = w_rxWord;
            end
            c_MODE_SWAP: begin
                w_nextL = w_rxWord;
                w_nextR = r_rxLHold;
            end
            default: begin
                w_nextL = '0;
                w_nextR = '0;
            end
        endcase
    end

    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wsQ      <= 1'b0;
            r_wsSeen   <= 1'b0;
            r_bitCnt   <= '0;
            r_rxSh     <= '0;
            r_rxLHold  <= '0;
            r_slotOk   <= 1'b0;
            r_leftOk   <= 1'b0;
            r_rxLeft   <= '0;
            r_rxRight  <= '0;
            r_rxValid  <= 1'b0;
            r_holdL    <= '0;
            r_holdR    <= '0;
            r_fresh    <= 1'b0;
            r_txArmed  <= 1'b0;
            r_actL     <= '0;
            r_actR     <= '0;
            r_underrun <= 1'b0;
            r_txSh     <= '0;
            r_sdata    <= 1'b0;
        end else begin
            r_wsQ     <= ws_i;
            r_wsSeen  <= 1'b1;
            r_rxValid <= 1'b0;
            r_sdata   <= r_txSh[WIDTH-1];

            if (w_boundary) begin
                r_bitCnt <= '0;
                r_rxSh   <= '0;
                r_slotOk <= 1'b1;
                r_txSh   <= ws_i ? r_actR : w_nextL;
            end else begin
                if (r_bitCnt != c_CNT_MAX) begin
                    r_rxSh   <= w_rxWord;
                    r_bitCnt <= r_bitCnt + 1'b1;
                end
                r_txSh <= r_txSh << 1;
            end

            // A left slot only counts toward arming if it began after reset.
            if (w_rise) begin
                r_rxLHold <= w_rxWord;
                r_leftOk  <= r_slotOk;
            end

            if (w_fall) begin
                if (r_slotOk && r_leftOk) begin
                    r_rxLeft  <= r_rxLHold;
                    r_rxRight <= w_rxWord;
                    r_rxValid <= 1'b1;
                end
                r_actL  <= w_nextL;
                r_actR  <= w_nextR;
                r_fresh <= 1'b0;
                if (w_underrunHit) begin
                    r_underrun <= 1'b1;
                end
            end

            if (dsp.txValid_i) begin
                r_holdL   <= dsp.txLeft_i;
                r_holdR   <= dsp.txRight_i;
                r_txArmed <= 1'b1;
                if (!w_fall) begin
                    r_fresh <= 1'b1;
                end
            end
        end
    end

    assign sclk_o        = sclk_i;
    assign ws_o          = r_wsQ;
    assign sdata_o       = r_sdata;
    assign underrun_o    = r_underrun;
    assign dsp.rxLeft_o  = r_rxLeft;
    assign dsp.rxRight_o = r_rxRight;
    assign dsp.rxValid_o = r_rxValid;

endmodule

`default_nettype wire

// File: tb/tb_i2s_stereo_core.sv
// ============================================================================
//  Module   : tb_i2s_stereo_core
//  Brief    : Directed-vector bench for i2s_stereo_core (WIDTH = 16).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_stereo_core;

    logic sclk_i;
    logic rst_n_i;
    logic ws_i;
    logic sdata_i;
    logic sclk_o;
    logic ws_o;
    logic sdata_o;
    logic underrun_o;

    i2s_stereo_core_if #(.WIDTH(16)) u_if ();

    i2s_stereo_core #(.WIDTH(16)) u_dut (
        .sclk_i     (sclk_i),
        .rst_n_i    (rst_n_i),
        .ws_i       (ws_i),
        .sdata_i    (sdata_i),
        .sclk_o     (sclk_o),
        .ws_o       (ws_o),
        .sdata_o    (sdata_o),
        .underrun_o (underrun_o),
        .dsp        (u_if.slave)
    );

    initial sclk_i = 1'b0;
    always #5 sclk_i = ~sclk_i;

    int          n_vec;
    int          n_err;
    logic        carry;
    int          rxCount;
    int          txFrames;
    int          widthErr;
    logic [15:0] rxL [0:31];
    logic [15:0] rxR [0:31];
    logic [31:0] txL [0:31];
    logic [31:0] txR [0:31];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One I2S frame from the external master; slot data is left-justified
    // in 32 bits and delayed by one bit relative to ws.
    task automatic send_frame(input int len, input logic [31:0] l, input logic [31:0] r,
                              input logic doTx, input logic [15:0] tl, input logic [15:0] tr,
                              input logic [1:0] nm);
        logic [31:0] d;
        for (int ch = 0; ch < 2; ch++) begin
            d = (ch == 1) ? r : l;
            for (int j = 0; j < len; j++) begin
                @(negedge sclk_i);
                ws_i    = ch[0];
                sdata_i = (j == 0) ? carry : d[31-(j-1)];
                u_if.txValid_i = doTx && (ch == 0) && (j == 2);
                if (doTx && ch == 0 && j == 2) begin
                    u_if.txLeft_i  = tl;
                    u_if.txRight_i = tr;
                end
                if (ch == 0 && j == 3) u_if.mode_i = nm;
            end
            carry = d[31-(len-1)];
        end
    endtask

    // Output monitor: records rx pair strobes and decodes the transmitted frames.
    initial begin
        int          idx;
        logic [31:0] cap;
        logic [31:0] lcap;
        logic        pws;
        logic        pv;
        idx = 0; cap = '0; lcap = '0; pws = 1'b0; pv = 1'b0;
        rxCount = 0; txFrames = 0; widthErr = 0;
        forever begin
            @(negedge sclk_i);
            if (!rst_n_i) begin
                idx = 0; cap = '0; pws = 1'b0; pv = 1'b0;
            end else begin
                if (u_if.rxValid_o) begin
                    if (pv) widthErr++;
                    if (rxCount < 32) begin
                        rxL[rxCount] = u_if.rxLeft_o;
                        rxR[rxCount] = u_if.rxRight_o;
                    end
                    rxCount++;
                end
                pv = u_if.rxValid_o;
                if (ws_o != pws) begin
                    if (idx < 32) cap[31-idx] = sdata_o;
                    if (pws) begin
                        if (txFrames < 32) begin
                            txL[txFrames] = lcap;
                            txR[txFrames] = cap;
                        end
                        txFrames++;
                    end else begin
                        lcap = cap;
                    end
                    cap = '0; idx = 0; pws = ws_o;
                end else begin
                    if (idx < 32) cap[31-idx] = sdata_o;
                    idx++;
                end
            end
        end
    end

    logic [15:0] expRxL [0:7] = '{16'hA5C3, 16'h5A5A, 16'h1111, 16'h3333,
                                  16'hFFFF, 16'h0000, 16'hABC0, 16'h1230};
    logic [15:0] expRxR [0:7] = '{16'h1234, 16'h0F0F, 16'h2222, 16'h4444,
                                  16'hFFFF, 16'h8000, 16'h5A50, 16'h4560};
    logic [31:0] expTxL [1:8] = '{32'h0, 32'h80010000, 32'h80010000, 32'h11110000,
                                  32'h44440000, 32'h0, 32'hFFF00000, 32'hFFF00000};
    logic [31:0] expTxR [1:8] = '{32'h0, 32'h7FFE0000, 32'h7FFE0000, 32'h22220000,
                                  32'h33330000, 32'h0, 32'hFFF00000, 32'hFFF00000};

    initial begin
        int c0;
        n_vec = 0; n_err = 0; carry = 1'b0;
        rst_n_i = 1'b0; ws_i = 1'b0; sdata_i = 1'b0;
        u_if.mode_i = 2'b00; u_if.txLeft_i = '0; u_if.txRight_i = '0; u_if.txValid_i = 1'b0;
        repeat (3) @(negedge sclk_i);
        check_val("rst_rxLeft",   32'(u_if.rxLeft_o),  32'h0);
        check_val("rst_rxRight",  32'(u_if.rxRight_o), 32'h0);
        check_val("rst_rxValid",  32'(u_if.rxValid_o), 32'h0);
        check_val("rst_ws_o",     32'(ws_o),           32'h0);
        check_val("rst_sdata_o",  32'(sdata_o),        32'h0);
        check_val("rst_underrun", 32'(underrun_o),     32'h0);
        rst_n_i = 1'b1;

        send_frame(32, 32'hDEAD0000, 32'hBEEF0000, 1'b0, 16'h0,    16'h0,    2'b00); // f0
        send_frame(32, 32'hA5C30000, 32'h12340000, 1'b1, 16'h8001, 16'h7FFE, 2'b00); // f1
        send_frame(32, 32'h5A5A0000, 32'h0F0F0000, 1'b0, 16'h0,    16'h0,    2'b00); // f2
        check_val("underrun_clear", 32'(underrun_o), 32'h0);
        send_frame(32, 32'h11110000, 32'h22220000, 1'b1, 16'h0F0F, 16'hF0F0, 2'b01); // f3
        check_val("underrun_set", 32'(underrun_o), 32'h1);
        send_frame(32, 32'h33330000, 32'h44440000, 1'b0, 16'h0,    16'h0,    2'b11); // f4
        send_frame(32, 32'hFFFF0000, 32'hFFFF0000, 1'b0, 16'h0,    16'h0,    2'b10); // f5
        send_frame(32, 32'h00000000, 32'h80000000, 1'b1, 16'hFFFF, 16'hFFFF, 2'b00); // f6
        send_frame(12, 32'hABC00000, 32'h5A500000, 1'b1, 16'hFFFF, 16'hFFFF, 2'b00); // f7
        send_frame(12, 32'h12300000, 32'h45600000, 1'b0, 16'h0,    16'h0,    2'b00); // f8
        send_frame(32, 32'h77770000, 32'h66660000, 1'b0, 16'h0,    16'h0,    2'b00); // f9
        check_val("underrun_sticky", 32'(underrun_o), 32'h1);

        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("rxL%0d", k), 32'(rxL[k]), 32'(expRxL[k]));
            check_val($sformatf("rxR%0d", k), 32'(rxR[k]), 32'(expRxR[k]));
        end
        for (int k = 1; k <= 8; k++) begin
            check_val($sformatf("txL%0d", k), txL[k], expTxL[k]);
            check_val($sformatf("txR%0d", k), txR[k], expTxR[k]);
        end
        check_val("rx_count", 32'(rxCount), 32'd8);

        // Left slot of f10 completes; reset lands in its right slot.
        for (int j = 0; j < 32; j++) begin
            @(negedge sclk_i);
            ws_i = 1'b0; sdata_i = (j == 0) ? carry : 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge sclk_i);
            ws_i = 1'b1; sdata_i = 1'b1;
        end
        check_val("pre_rst_rxLeft", 32'(u_if.rxLeft_o), 32'h7777);
        check_val("pre_rst_ws_o",   32'(ws_o),          32'h1);
        #2 rst_n_i = 1'b0;
        #1;
        check_val("mid_rst_rxLeft",   32'(u_if.rxLeft_o),  32'h0);
        check_val("mid_rst_rxRight",  32'(u_if.rxRight_o), 32'h0);
        check_val("mid_rst_ws_o",     32'(ws_o),           32'h0);
        check_val("mid_rst_sdata_o",  32'(sdata_o),        32'h0);
        check_val("mid_rst_underrun", 32'(underrun_o),     32'h0);
        for (int j = 0; j < 22; j++) begin
            @(negedge sclk_i);
            rst_n_i = 1'b1; ws_i = 1'b1; sdata_i = 1'b0;
        end
        carry = 1'b0;
        c0 = rxCount;
        send_frame(32, 32'h0BAD0000, 32'hBEEF0000, 1'b0, 16'h0, 16'h0, 2'b00);
        check_val("no_rx_before_pair", 32'(rxCount), 32'(c0));
        send_frame(32, 32'h00000000, 32'h00000000, 1'b0, 16'h0, 16'h0, 2'b00);
        check_val("rx_after_pair", 32'(rxCount), 32'(c0 + 1));
        check_val("post_rst_rxLeft",  32'(u_if.rxLeft_o),  32'h0BAD);
        check_val("post_rst_rxRight", 32'(u_if.rxRight_o), 32'hBEEF);
        check_val("rxvalid_width", 32'(widthErr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
